// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl -- multi-cycle control FSM for an RV32I core.
// It sequences FETCH / DECODE / EXEC / MEM / WB over a shared datapath with a
// single memory port, decodes the IR opcode into datapath selects and write
// enables, and counts retired instructions.
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   opcode                IR[6:0] of the latched instruction
//   br_taken              branch-compare result (sampled in EXEC)
//   mem_ready / mem_req   memory handshake; mem_we, mem_addr_sel qualify the request
//   ir_we, pc_we, pc_sel  IR latch, PC update and PC source select
//   imm_sel, alu_a_sel, alu_b_sel, reg_we, wb_sel   datapath controls
//   trap                  sticky: illegal opcode or memory timeout
//   instret               retired-instruction counter (wraps)
//   state_o               current FSM state, for debug
module rv_multicycle_ctrl #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned MEM_TMO = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [2:0]       imm_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam bit          TMO_EN   = (MEM_TMO != 0);
  localparam int unsigned TMO_W    = (MEM_TMO > 1) ? $clog2(MEM_TMO) + 1 : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_EN ? TMO_W'(MEM_TMO - 1) : '0;

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               trap_q, trap_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  logic [2:0]         imm_dec;
  logic               legal;

  always_comb begin
    legal   = 1'b1;
    imm_dec = 3'd0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: imm_dec = 3'd0;
      OP_STORE:                 imm_dec = 3'd1;
      OP_BRANCH:                imm_dec = 3'd2;
      OP_LUI:                   imm_dec = 3'd3;
      OP_JAL:                   imm_dec = 3'd4;
      default:                  legal   = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    tmo_d        = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    imm_sel      = 3'd0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 2'd0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (TMO_EN && tmo_q == TMO_LAST) begin
          state_d = S_TRAP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DECODE: begin
        imm_sel = imm_dec;
        state_d = legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        imm_sel = imm_dec;
        case (opcode)
          OP_IMM, OP_LUI: begin
            alu_b_sel = 1'b1;
            state_d   = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_b_sel = 1'b1;
            state_d   = S_MEM;
          end
          OP_BRANCH: begin
            if (br_taken) begin
              pc_we  = 1'b1;
              pc_sel = 2'd1;
            end
            state_d = S_FETCH;
          end
          OP_JAL: begin
            // Target is old PC + J-immediate.
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
            pc_we     = 1'b1;
            pc_sel    = 2'd1;
            reg_we    = 1'b1;
            wb_sel    = 2'd2;
            state_d   = S_FETCH;
          end
          OP_JALR: begin
            alu_b_sel = 1'b1;
            pc_we     = 1'b1;
            pc_sel    = 2'd2;
            reg_we    = 1'b1;
            wb_sel    = 2'd2;
            state_d   = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        imm_sel      = imm_dec;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OP_STORE);
        if (mem_ready) begin
          state_d = (opcode == OP_STORE) ? S_FETCH : S_WB;
        end else if (TMO_EN && tmo_q == TMO_LAST) begin
          state_d = S_TRAP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WB: begin
        imm_sel = imm_dec;
        reg_we  = 1'b1;
        wb_sel  = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // Reset state is FETCH, whose decode would raise mem_req; gate every
    // control output so an asserted reset drops the request at once.
    if (!rst_n) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 2'd0;
      imm_sel      = 3'd0;
      alu_a_sel    = 1'b0;
      alu_b_sel    = 1'b0;
      reg_we       = 1'b0;
      wb_sel       = 2'd0;
    end
  end

  always_comb begin
    trap_d    = trap_q | (state_d == S_TRAP);
    instret_d = instret_q;
    if (state_d == S_FETCH && state_q != S_FETCH) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      tmo_q     <= '0;
      trap_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      trap_q    <= trap_d;
      instret_q <= instret_d;
    end
  end

  assign trap    = trap_q;
  assign instret = instret_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
module tb_rv_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'h13;
  logic        br_taken = 1'b0;
  logic        mem_ready = 1'b1;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  imm_sel, state_o;
  logic        alu_a_sel, alu_b_sel, reg_we, trap;
  logic [31:0] instret;

  // Second instance with the memory timeout enabled and its own reset.
  logic        rst_t_n = 1'b0;
  logic [6:0]  opcode_t = 7'h13;
  logic        br_t = 1'b0;
  logic        ready_t = 1'b0;
  logic        t_req, t_we, t_asel, t_irwe, t_pcwe, t_alua, t_alub, t_regwe, t_trap;
  logic [1:0]  t_pcsel, t_wbsel;
  logic [2:0]  t_imm, t_state;
  logic [31:0] t_instret;

  always #5 clk = ~clk;

  rv_multicycle_ctrl #(.CNT_W(32), .MEM_TMO(0)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_taken(br_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .imm_sel(imm_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .reg_we(reg_we), .wb_sel(wb_sel), .trap(trap), .instret(instret),
    .state_o(state_o)
  );

  rv_multicycle_ctrl #(.CNT_W(32), .MEM_TMO(4)) dut_t (
    .clk(clk), .rst_n(rst_t_n), .opcode(opcode_t), .br_taken(br_t),
    .mem_ready(ready_t), .mem_req(t_req), .mem_we(t_we),
    .mem_addr_sel(t_asel), .ir_we(t_irwe), .pc_we(t_pcwe), .pc_sel(t_pcsel),
    .imm_sel(t_imm), .alu_a_sel(t_alua), .alu_b_sel(t_alub),
    .reg_we(t_regwe), .wb_sel(t_wbsel), .trap(t_trap), .instret(t_instret),
    .state_o(t_state)
  );

  typedef struct {
    string name;
    int cycles; int reqcyc; int irwe; int regwe; int regwe_st;
    int wbsel;  int jumps;  int pcsel; int memwe; int instret;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_instret = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: accumulates one instruction's activity per cycle and, when the
  // FSM comes back to FETCH, pops the expected record and compares.
  int a_cyc, a_req, a_irwe, a_regwe, a_regwe_st, a_wbsel, a_jumps, a_pcsel, a_memwe;
  int prev_st;
  exp_t e;

  task automatic clear_acc();
    a_cyc = 0; a_req = 0; a_irwe = 0; a_regwe = 0; a_regwe_st = 0;
    a_wbsel = 0; a_jumps = 0; a_pcsel = 0; a_memwe = 0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_st = 0;
      clear_acc();
    end else begin
      if (state_o == 3'd0 && prev_st >= 1 && prev_st <= 4) begin
        if (q.size() == 0) begin
          chk("unexpected_retire", 1, 0);
        end else begin
          e = q.pop_front();
          chk({e.name, ".cycles"},   a_cyc,      e.cycles);
          chk({e.name, ".req_cyc"},  a_req,      e.reqcyc);
          chk({e.name, ".ir_we"},    a_irwe,     e.irwe);
          chk({e.name, ".reg_we"},   a_regwe,    e.regwe);
          chk({e.name, ".reg_we_st"},a_regwe_st, e.regwe_st);
          chk({e.name, ".wb_sel"},   a_wbsel,    e.wbsel);
          chk({e.name, ".jumps"},    a_jumps,    e.jumps);
          chk({e.name, ".pc_sel"},   a_pcsel,    e.pcsel);
          chk({e.name, ".mem_we"},   a_memwe,    e.memwe);
          chk({e.name, ".instret"},  instret,    e.instret);
        end
        clear_acc();
      end
      a_cyc++;
      if (mem_req) a_req++;
      if (ir_we) a_irwe++;
      if (reg_we) begin
        a_regwe++;
        a_regwe_st = state_o;
        a_wbsel    = wb_sel;
      end
      if (pc_we && pc_sel != 2'd0) begin
        a_jumps++;
        a_pcsel = pc_sel;
      end
      if (mem_req && mem_we) a_memwe++;
      prev_st = state_o;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction starting in the current FETCH cycle; the fetch is
  // stalled for `stall` cycles. Returns in the next FETCH (or TRAP) cycle.
  task automatic run_insn(input string nm, input logic [6:0] op, input logic br,
                          input int stall, input int cyc, input int reqc,
                          input int rw, input int rw_st, input int wb,
                          input int jmp, input int ps, input int mw);
    exp_t x;
    int   n;
    exp_instret++;
    x.name = nm; x.cycles = cyc; x.reqcyc = reqc; x.irwe = 1; x.regwe = rw;
    x.regwe_st = rw_st; x.wbsel = wb; x.jumps = jmp; x.pcsel = ps;
    x.memwe = mw; x.instret = exp_instret;
    q.push_back(x);
    opcode    = op;
    br_taken  = br;
    mem_ready = (stall == 0);
    for (int i = 0; i < stall; i++) step();
    mem_ready = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (state_o != 3'd0 && state_o != 3'd5 && n < 50);
    if (n >= 50) chk({nm, ".completion_timeout"}, n, 0);
  endtask

  initial begin
    int hits;
    // Asynchronous reset state.
    #3;
    chk("rst.state", state_o, 0);
    chk("rst.instret", instret, 0);
    chk("rst.trap", trap, 0);
    chk("rst.mem_req", mem_req, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    //        name      op     br stall cyc req rw st wb jmp ps mw
    run_insn("ADDI",  7'h13, 0, 0,  4, 1, 1, 4, 0, 0, 0, 0);
    run_insn("SW",    7'h23, 0, 0,  4, 2, 0, 0, 0, 0, 0, 1);
    run_insn("LW",    7'h03, 0, 0,  5, 2, 1, 4, 1, 0, 0, 0);
    run_insn("LUI",   7'h37, 0, 0,  4, 1, 1, 4, 0, 0, 0, 0);
    run_insn("BEQ_T", 7'h63, 1, 0,  3, 1, 0, 0, 0, 1, 1, 0);
    run_insn("BEQ_N", 7'h63, 0, 0,  3, 1, 0, 0, 0, 0, 0, 0);
    run_insn("JAL",   7'h6F, 0, 0,  3, 1, 1, 2, 2, 1, 1, 0);
    run_insn("JALR",  7'h67, 0, 0,  3, 1, 1, 2, 2, 1, 2, 0);
    run_insn("STALL", 7'h13, 0, 7, 11, 8, 1, 4, 0, 0, 0, 0);

    // Reset in the middle of a stalled load's MEM phase.
    opcode = 7'h03;
    mem_ready = 1'b1;
    step();
    step();
    mem_ready = 1'b0;
    step();
    chk("ldrst.in_mem", state_o, 3);
    chk("ldrst.req_before", mem_req, 1);
    chk("ldrst.asel_before", mem_addr_sel, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ldrst.req_async", mem_req, 0);
    chk("ldrst.asel_async", mem_addr_sel, 0);
    chk("ldrst.state_async", state_o, 0);
    chk("ldrst.instret_async", instret, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_ready = 1'b1;
    exp_instret = 0;
    chk("ldrst.state_after", state_o, 0);
    chk("ldrst.instret_after", instret, 0);
    run_insn("ADDI2", 7'h13, 0, 0, 4, 1, 1, 4, 0, 0, 0, 0);

    // Illegal opcode: DECODE then sticky TRAP, no memory traffic.
    opcode = 7'h7F;
    step();
    chk("ill.decode", state_o, 1);
    step();
    chk("ill.trap_state", state_o, 5);
    chk("ill.trap", trap, 1);
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (mem_req || reg_we || pc_we || state_o != 3'd5 || !trap) hits++;
    end
    chk("ill.sticky_quiet", hits, 0);

    // Timeout instance: 4 waiting FETCH cycles then TRAP.
    @(posedge clk);
    #1 rst_t_n = 1'b1;
    step(); step(); step();
    chk("tmo.still_fetch", t_state, 0);
    chk("tmo.req_held", t_req, 1);
    chk("tmo.no_trap_yet", t_trap, 0);
    step();
    chk("tmo.trap_state", t_state, 5);
    chk("tmo.trap", t_trap, 1);
    chk("tmo.req_dropped", t_req, 0);

    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
